// File: rtl/basic_gates_checker_if.sv
// Vector channel from a gate-under-test observer into basic_gates_checker:
// the applied (a, b) pair, the seven observed gate outputs and the valid/ready handshake.
interface basic_gates_checker_if;
  logic in_valid;
  logic in_ready;
  logic in_a;
  logic in_b;
  logic y_and;
  logic y_or;
  logic y_not;
  logic y_nand;
  logic y_nor;
  logic y_xor;
  logic y_xnor;

  modport master (
    output in_valid, in_a, in_b, y_and, y_or, y_not, y_nand, y_nor, y_xor, y_xnor,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_a, in_b, y_and, y_or, y_not, y_nand, y_nor, y_xor, y_xnor,
    output in_ready
  );
endinterface

// File: rtl/basic_gates_checker.sv
// Response checker for AND/OR/NOT/NAND/NOR/XOR/XNOR: sticky error flags, counts, coverage.
// Define GATE_CHECKER_COVERAGE_EN to track input coverage and require full coverage for pass.
module basic_gates_checker #(
  parameter int unsigned NUM_VECTORS = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  basic_gates_checker_if.slave     vec,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [6:0]               err_mask,
  output logic [CNT_W-1:0]         err_count,
  output logic [CNT_W-1:0]         vec_count,
  output logic [3:0]               cov_mask
);

  // Run length is tracked separately from vec_count, which may wrap when CNT_W is narrow.
  localparam int unsigned AccW = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [6:0]       err_mask_q, err_mask_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [CNT_W-1:0] vec_count_q, vec_count_d;
  logic [AccW-1:0]  acc_q, acc_d;
  logic             pass_q, pass_d;

  logic       accept;
  logic       last;
  logic       clear;
  logic       cov_ok;
  logic [6:0] expected;
  logic [6:0] observed;
  logic [6:0] mismatch;

  assign busy         = (state_q == StRun);
  assign done         = (state_q == StDone);
  assign vec.in_ready = busy;
  assign accept       = busy & vec.in_valid;
  assign last         = accept & (acc_q == AccW'(NUM_VECTORS - 1));
  assign clear        = start & ((state_q == StIdle) | (state_q == StDone));

  assign expected = {~(vec.in_a ^ vec.in_b), vec.in_a ^ vec.in_b, ~(vec.in_a | vec.in_b),
                     ~(vec.in_a & vec.in_b), ~vec.in_a, vec.in_a | vec.in_b,
                     vec.in_a & vec.in_b};
  assign observed = {vec.y_xnor, vec.y_xor, vec.y_nor, vec.y_nand, vec.y_not, vec.y_or,
                     vec.y_and};
  assign mismatch = observed ^ expected;

`ifdef GATE_CHECKER_COVERAGE_EN
  logic [3:0] cov_q, cov_d;

  always_comb begin
    cov_d = cov_q;
    if (clear) begin
      cov_d = 4'h0;
    end else if (accept) begin
      cov_d[{vec.in_a, vec.in_b}] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cov_q <= 4'h0;
    end else begin
      cov_q <= cov_d;
    end
  end

  assign cov_ok   = (cov_d == 4'hF);
  assign cov_mask = cov_q;
`else
  assign cov_ok   = 1'b1;
  assign cov_mask = 4'h0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (start) state_d = StRun;
      StRun:          if (last)  state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  always_comb begin
    err_mask_d  = err_mask_q;
    err_count_d = err_count_q;
    vec_count_d = vec_count_q;
    acc_d       = acc_q;
    pass_d      = pass_q;
    if (clear) begin
      err_mask_d  = '0;
      err_count_d = '0;
      vec_count_d = '0;
      acc_d       = '0;
      pass_d      = 1'b0;
    end else if (accept) begin
      err_mask_d  = err_mask_q | mismatch;
      if ((|mismatch) && (err_count_q != '1)) begin
        err_count_d = err_count_q + CNT_W'(1);
      end
      vec_count_d = vec_count_q + CNT_W'(1);
      acc_d       = acc_q + AccW'(1);
      // pass is latched on the final accept so it is valid the cycle done rises.
      if (last) begin
        pass_d = ((err_mask_q | mismatch) == 7'h0) & cov_ok;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      err_mask_q  <= '0;
      err_count_q <= '0;
      vec_count_q <= '0;
      acc_q       <= '0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      err_mask_q  <= err_mask_d;
      err_count_q <= err_count_d;
      vec_count_q <= vec_count_d;
      acc_q       <= acc_d;
      pass_q      <= pass_d;
    end
  end

  assign pass      = pass_q;
  assign err_mask  = err_mask_q;
  assign err_count = err_count_q;
  assign vec_count = vec_count_q;

endmodule

// File: tb/tb_basic_gates_checker.sv
// Bench for basic_gates_checker: directed and randomized runs against a behavioural model,
// on a default instance and on a narrow-counter instance (CNT_W=2, NUM_VECTORS=6).
module tb_basic_gates_checker;

`ifdef GATE_CHECKER_COVERAGE_EN
  localparam int CovEn = 1;
`else
  localparam int CovEn = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start0, start1;

  basic_gates_checker_if bif0 ();
  basic_gates_checker_if bif1 ();

  logic       busy0, done0, pass0, busy1, done1, pass1;
  logic [6:0] mask0, mask1;
  logic [7:0] errc0, vecc0;
  logic [1:0] errc1, vecc1;
  logic [3:0] cov0, cov1;

  basic_gates_checker dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start0),
    .vec      (bif0),
    .busy     (busy0),
    .done     (done0),
    .pass     (pass0),
    .err_mask (mask0),
    .err_count(errc0),
    .vec_count(vecc0),
    .cov_mask (cov0)
  );

  basic_gates_checker #(
    .NUM_VECTORS(6),
    .CNT_W      (2)
  ) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start1),
    .vec      (bif1),
    .busy     (busy1),
    .done     (done1),
    .pass     (pass1),
    .err_mask (mask1),
    .err_count(errc1),
    .vec_count(vecc1),
    .cov_mask (cov1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int sel   = 0;

  // Reference model of the selected instance's run.
  int       m_run, m_done, m_vec, m_err;
  bit [6:0] m_mask;
  bit [3:0] m_cov;

  function automatic bit [6:0] gold(input bit a, input bit b);
    int s = int'(a) + int'(b);
    int p = int'(a) * int'(b);
    gold[0] = (p == 1);
    gold[1] = (s > 0);
    gold[2] = (a == 0);
    gold[3] = (p == 0);
    gold[4] = (s == 0);
    gold[5] = (s == 1);
    gold[6] = (s != 1);
  endfunction

  function automatic int cnt_w();
    return (sel == 0) ? 8 : 2;
  endfunction

  function automatic int num_vec();
    return (sel == 0) ? 4 : 6;
  endfunction

  task automatic model_reset(input int run);
    m_run  = run;
    m_done = 0;
    m_vec  = 0;
    m_err  = 0;
    m_mask = '0;
    m_cov  = '0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] o_busy, o_done, o_pass, o_rdy, o_mask, o_errc, o_vecc, o_cov;
    int          exp_pass;
    if (sel == 0) begin
      o_busy = 32'(busy0); o_done = 32'(done0); o_pass = 32'(pass0); o_rdy = 32'(bif0.in_ready);
      o_mask = 32'(mask0); o_errc = 32'(errc0); o_vecc = 32'(vecc0); o_cov = 32'(cov0);
    end else begin
      o_busy = 32'(busy1); o_done = 32'(done1); o_pass = 32'(pass1); o_rdy = 32'(bif1.in_ready);
      o_mask = 32'(mask1); o_errc = 32'(errc1); o_vecc = 32'(vecc1); o_cov = 32'(cov1);
    end
    exp_pass = (m_done == 1 && m_mask == 0 && (CovEn == 0 || m_cov == 4'hF)) ? 1 : 0;
    check({tag, ".busy"}, o_busy, 32'(m_run));
    check({tag, ".done"}, o_done, 32'(m_done));
    check({tag, ".in_ready"}, o_rdy, 32'(m_run));
    check({tag, ".pass"}, o_pass, 32'(exp_pass));
    check({tag, ".err_mask"}, o_mask, 32'(m_mask));
    check({tag, ".err_count"}, o_errc, 32'(m_err));
    check({tag, ".vec_count"}, o_vecc, 32'(m_vec % (1 << cnt_w())));
    check({tag, ".cov_mask"}, o_cov, (CovEn != 0) ? 32'(m_cov) : 32'h0);
  endtask

  task automatic set_vec(input bit v, input bit a, input bit b, input bit [6:0] y);
    if (sel == 0) begin
      bif0.in_valid = v; bif0.in_a = a; bif0.in_b = b;
      bif0.y_and = y[0]; bif0.y_or = y[1]; bif0.y_not = y[2]; bif0.y_nand = y[3];
      bif0.y_nor = y[4]; bif0.y_xor = y[5]; bif0.y_xnor = y[6];
    end else begin
      bif1.in_valid = v; bif1.in_a = a; bif1.in_b = b;
      bif1.y_and = y[0]; bif1.y_or = y[1]; bif1.y_not = y[2]; bif1.y_nand = y[3];
      bif1.y_nor = y[4]; bif1.y_xor = y[5]; bif1.y_xnor = y[6];
    end
  endtask

  // Present one vector for one cycle; it only counts if the checker is in RUN.
  task automatic accept(input bit a, input bit b, input bit [6:0] y);
    bit [6:0] mis;
    set_vec(1'b1, a, b, y);
    @(posedge clk);
    #1;
    set_vec(1'b0, 1'b0, 1'b0, 7'h0);
    if (m_run == 1) begin
      mis    = y ^ gold(a, b);
      m_mask = m_mask | mis;
      if (mis != 0 && m_err < (1 << cnt_w()) - 1) m_err++;
      m_vec++;
      m_cov[{a, b}] = 1'b1;
      if (m_vec == num_vec()) begin
        m_run  = 0;
        m_done = 1;
      end
    end
    check_all("acc");
  endtask

  task automatic do_start();
    if (sel == 0) start0 = 1'b1;
    else start1 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
    if (m_run == 0) model_reset(1);
    check_all("start");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check_all("idle");
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "timeout");
  end

  initial begin
    bit       ra, rb;
    bit [6:0] ry;
    int       k;

    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    sel = 1; set_vec(1'b0, 1'b0, 1'b0, 7'h0);
    sel = 0; set_vec(1'b0, 1'b0, 1'b0, 7'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset(0);
    check_all("reset");

    // Full coverage, correct gates.
    do_start();
    accept(1'b0, 1'b0, gold(1'b0, 1'b0));
    accept(1'b0, 1'b1, gold(1'b0, 1'b1));
    accept(1'b1, 1'b0, gold(1'b1, 1'b0));
    accept(1'b1, 1'b1, gold(1'b1, 1'b1));
    // Input while DONE is dropped.
    accept(1'b1, 1'b1, ~gold(1'b1, 1'b1));

    // Restart from DONE; xor stuck low on vector 10.
    do_start();
    accept(1'b0, 1'b0, gold(1'b0, 1'b0));
    accept(1'b0, 1'b1, gold(1'b0, 1'b1));
    accept(1'b1, 1'b0, gold(1'b1, 1'b0) & 7'h5F);
    accept(1'b1, 1'b1, gold(1'b1, 1'b1));

    // Only vector 00 seen.
    do_start();
    repeat (4) accept(1'b0, 1'b0, gold(1'b0, 1'b0));

    // Reset mid-run discards everything.
    do_start();
    accept(1'b0, 1'b1, gold(1'b0, 1'b1));
    accept(1'b1, 1'b1, gold(1'b1, 1'b1) ^ 7'h01);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset(0);
    check_all("midreset");

    // Clean run with valid gaps and a start pulse while running.
    do_start();
    accept(1'b1, 1'b1, gold(1'b1, 1'b1));
    idle(1);
    do_start();
    idle(2);
    accept(1'b0, 1'b0, gold(1'b0, 1'b0));
    accept(1'b0, 1'b1, gold(1'b0, 1'b1));
    accept(1'b1, 1'b0, gold(1'b1, 1'b0));

    // Randomized runs with occasional single-gate faults and valid gaps.
    for (int r = 0; r < 8; r++) begin
      do_start();
      while (m_done == 0) begin
        if ($urandom_range(3) == 0) idle(1);
        ra = 1'($urandom_range(1));
        rb = 1'($urandom_range(1));
        ry = gold(ra, rb);
        if ($urandom_range(4) == 0) begin
          k = int'($urandom_range(6));
          ry[k] = ~ry[k];
        end
        accept(ra, rb, ry);
      end
    end

    // Narrow instance: and stuck-at-1 on repeated 00 saturates err_count, vec_count wraps.
    sel = 1;
    model_reset(0);
    check_all("reset1");
    do_start();
    repeat (6) accept(1'b0, 1'b0, gold(1'b0, 1'b0) | 7'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
